i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
- Synthesizable I2C target (responder) that answers the I2C master driven by the team's I2C agent and Wishbone I2C master.
- Holds a small byte-wide register file, addressed over I2C by a pointer byte.
- Exposes write strobes and a local read port to on-chip logic.
- Serves as the DUT-side target in bus-level tests and as a reusable peripheral endpoint.

Parameters:
- SLV_ADDR, 7'h50, 7-bit I2C address this target responds to.
- DEPTH, 16, number of bytes in the register file; a power of 2, 2..256.
- AW, $clog2(DEPTH), register index width.

Ports:
- wb_clk_i  in  1  system clock; all logic is synchronous to it.
- wb_rst_i  in  1  asynchronous, active-high reset.
- scl_pad_i  in  1  SCL line from pad. This block never drives SCL and never stretches the clock.
- sda_pad_i  in  1  SDA line from pad.
- sda_pad_o  out  1  constant 0 (open-drain).
- sda_padoen_o  out  1  SDA output enable, active low. 0 pulls SDA low; 1 releases it.
- busy_o  out  1  high from address match until STOP or repeated START.
- wr_stb_o  out  1  one-cycle pulse when a data byte is written to the register file.
- wr_addr_o  out  AW  register index of the last write.
- wr_data_o  out  8  data of the last write.
- loc_addr_i  in  AW  local read index.
- loc_data_o  out  8  regfile[loc_addr_i], combinational.

Behaviour:
- Reset values:
  - sda_padoen_o=1; busy_o=0; wr_stb_o=0; wr_addr_o=0; wr_data_o=0.
  - Register file all 0; pointer=0; state IDLE.
  - Synchronizers preset to 1 (bus idle).
- Input conditioning:
  - scl_pad_i and sda_pad_i each pass through a 2-flop synchronizer plus one delay flop for edge detect.
  - Detection latency is 3 wb_clk cycles.
  - wb_clk_i must be at least 16x the SCL frequency.
- Bus event detection, using synchronized signals:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SCL rise and SCL fall are one-cycle pulses.
- Data timing:
  - SDA is sampled on SCL rise.
  - sda_padoen_o changes only on the cycle after an SCL fall is detected.
- Priority: START and STOP are evaluated first in every state.
  - STOP -> IDLE, release SDA, busy_o=0.
  - START (including repeated START) -> ADDR, clear bit counter and busy_o, release SDA.
- State machine (8 data bits per byte, MSB first; bit counter 0..7; ninth clock is ACK):
  - IDLE: wait for START.
  - ADDR: shift 8 bits ({addr[6:0], rw}). After the 8th SCL rise, compare against SLV_ADDR.
    - Match: on the next SCL fall, drive ACK (padoen=0), set busy_o, go to ADDR_ACK.
    - Mismatch: go to IDLE, never driving SDA.
  - ADDR_ACK: on SCL fall, release SDA.
    - rw=0: go to WR_PTR.
    - rw=1: load shift register with regfile[ptr], drive MSB in the same cycle, go to RD_DATA.
  - WR_PTR: shift 8 bits. ptr <= byte[AW-1:0]; upper bits are ignored. ACK on the next fall, then PTR_ACK.
  - PTR_ACK: release on SCL fall, go to WR_DATA.
  - WR_DATA: shift 8 bits. After the 8th rise:
    - regfile[ptr] <= byte.
    - wr_stb_o=1 for one cycle; wr_addr_o=ptr; wr_data_o=byte.
    - ptr <= ptr+1, wrapping modulo DEPTH.
    - ACK on the next fall, then DATA_ACK.
  - DATA_ACK: release on SCL fall, go back to WR_DATA. Every data byte is ACKed.
  - RD_DATA: on each SCL fall, drive the next bit (padoen = bit value; 1 = released). After the 8th fall, release SDA, ptr <= ptr+1 (wrap), go to RD_ACK.
  - RD_ACK: sample SDA on SCL rise.
    - 0 (ACK): on the next fall, load regfile[ptr], drive MSB, go to RD_DATA.
    - 1 (NACK): go to WAIT_P, SDA released, busy_o held until STOP or START.
- Simultaneous events:
  - A local read concurrent with an I2C write returns the pre-write value in that cycle.
  - A START during any ACK drive releases SDA in the same cycle.
- Reset mid-transfer: all outputs take reset values immediately (asynchronous); the FSM resumes only at the next START.
- Pointer persists across transactions (not cleared by STOP), so a read following a write-pointer-only transaction starts at that pointer.

Test Plan:
- Write 0x50+W, ptr 0x03, data 0xA5, 0x3C, STOP:
  - ACK on all 4 bytes.
  - wr_stb_o pulses twice: (3,A5) then (4,3C).
  - loc_data_o at addresses 3 and 4 = A5, 3C.
- Write ptr 0x03, repeated START, 0x50+R, read 2 bytes with ACK then NACK, STOP:
  - Master receives A5, 3C.
  - busy_o falls at STOP.
- Address 0x51+W:
  - No ACK (SDA stays 1 at the 9th clock).
  - No wr_stb_o; busy_o stays 0.
- Write ptr 0x0F (DEPTH=16), data 0x11, 0x22: writes land at 0x0F, then 0x00 (wrap).
- Assert wb_rst_i mid-byte during WR_DATA:
  - Outputs return to reset values; regfile is cleared.
  - The next full transaction completes correctly.
- STOP issued in the middle of an address byte: the target returns to IDLE without driving SDA, and the following transaction is ACKed.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file addressed by a pointer byte.
// SCL/SDA are oversampled on wb_clk_i; SCL is never driven or stretched.
module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    parameter int         AW       = $clog2(DEPTH)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          scl_pad_i,
    input  logic          sda_pad_i,
    output logic          sda_pad_o,
    output logic          sda_padoen_o,
    output logic          busy_o,
    output logic          wr_stb_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    input  logic [AW-1:0] loc_addr_i,
    output logic [7:0]    loc_data_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_PTR,
        S_PTR_ACK,
        S_WR_DATA,
        S_DATA_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_P
    } state_t;

    // [0],[1] synchronize, [2] is the previous synchronized value for edge detect
    logic [2:0] scl_pipe, sda_pipe;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scl_pipe <= 3'b111;
            sda_pipe <= 3'b111;
        end else begin
            scl_pipe <= {scl_pipe[1:0], scl_pad_i};
            sda_pipe <= {sda_pipe[1:0], sda_pad_i};
        end
    end

    logic scl, scl_d, sda, sda_d;
    logic scl_rise, scl_fall, start, stop;

    assign scl      = scl_pipe[1];
    assign scl_d    = scl_pipe[2];
    assign sda      = sda_pipe[1];
    assign sda_d    = sda_pipe[2];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start    = scl & scl_d & sda_d & ~sda;
    assign stop     = scl & scl_d & ~sda_d & sda;

    state_t                     state, state_nxt;
    logic [6:0]                 rx_sr, rx_sr_nxt;
    logic [6:0]                 tx_sr, tx_sr_nxt;
    logic [2:0]                 bit_cnt, bit_cnt_nxt;
    logic                       byte_done, byte_done_nxt;
    logic                       rw, rw_nxt;
    logic [AW-1:0]              ptr, ptr_nxt;
    logic                       padoen, padoen_nxt;
    logic                       busy, busy_nxt;
    logic                       wr_stb, wr_stb_nxt;
    logic [AW-1:0]              wr_addr, wr_addr_nxt;
    logic [7:0]                 wr_data, wr_data_nxt;
    logic                       rf_we;
    logic [DEPTH-1:0][7:0]      rf;
    logic [7:0]                 rx_byte;
    logic [7:0]                 rd_byte;

    assign rx_byte = {rx_sr, sda};
    assign rd_byte = rf[ptr];

    always_comb begin
        state_nxt     = state;
        rx_sr_nxt     = rx_sr;
        tx_sr_nxt     = tx_sr;
        bit_cnt_nxt   = bit_cnt;
        byte_done_nxt = byte_done;
        rw_nxt        = rw;
        ptr_nxt       = ptr;
        padoen_nxt    = padoen;
        busy_nxt      = busy;
        wr_stb_nxt    = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        rf_we         = 1'b0;

        if (start) begin
            state_nxt     = S_ADDR;
            bit_cnt_nxt   = 3'd0;
            byte_done_nxt = 1'b0;
            busy_nxt      = 1'b0;
            padoen_nxt    = 1'b1;
        end else if (stop) begin
            state_nxt     = S_IDLE;
            byte_done_nxt = 1'b0;
            busy_nxt      = 1'b0;
            padoen_nxt    = 1'b1;
        end else begin
            case (state)
                S_ADDR, S_WR_PTR, S_WR_DATA: begin
                    if (scl_rise) begin
                        rx_sr_nxt   = rx_byte[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done_nxt = 1'b1;
                            case (state)
                                S_ADDR: begin
                                    // a foreign address drops us back to idle without touching SDA
                                    if (rx_byte[7:1] != SLV_ADDR) begin
                                        state_nxt     = S_IDLE;
                                        byte_done_nxt = 1'b0;
                                    end
                                    rw_nxt = rx_byte[0];
                                end
                                S_WR_PTR: ptr_nxt = rx_byte[AW-1:0];
                                default: begin
                                    rf_we       = 1'b1;
                                    wr_stb_nxt  = 1'b1;
                                    wr_addr_nxt = ptr;
                                    wr_data_nxt = rx_byte;
                                    ptr_nxt     = ptr + AW'(1);
                                end
                            endcase
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        padoen_nxt    = 1'b0;
                        case (state)
                            S_ADDR: begin
                                state_nxt = S_ADDR_ACK;
                                busy_nxt  = 1'b1;
                            end
                            S_WR_PTR: state_nxt = S_PTR_ACK;
                            default:  state_nxt = S_DATA_ACK;
                        endcase
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nxt = 3'd0;
                        if (rw) begin
                            tx_sr_nxt  = rd_byte[6:0];
                            padoen_nxt = rd_byte[7];
                            state_nxt  = S_RD_DATA;
                        end else begin
                            padoen_nxt = 1'b1;
                            state_nxt  = S_WR_PTR;
                        end
                    end
                end
                S_PTR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        padoen_nxt  = 1'b1;
                        bit_cnt_nxt = 3'd0;
                        state_nxt   = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            padoen_nxt    = 1'b1;
                            ptr_nxt       = ptr + AW'(1);
                            bit_cnt_nxt   = 3'd0;
                            byte_done_nxt = 1'b0;
                            state_nxt     = S_RD_ACK;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                            padoen_nxt  = tx_sr[6];
                            tx_sr_nxt   = {tx_sr[5:0], 1'b0};
                        end
                    end
                end
                S_RD_ACK: begin
                    // byte_done marks a sampled ACK; the next byte goes out on the following fall
                    if (scl_rise) begin
                        if (sda) state_nxt = S_WAIT_P;
                        else     byte_done_nxt = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        bit_cnt_nxt   = 3'd0;
                        tx_sr_nxt     = rd_byte[6:0];
                        padoen_nxt    = rd_byte[7];
                        state_nxt     = S_RD_DATA;
                    end
                end
                S_IDLE, S_WAIT_P: begin
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            rx_sr     <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            ptr       <= '0;
            padoen    <= 1'b1;
            busy      <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nxt;
            rx_sr     <= rx_sr_nxt;
            tx_sr     <= tx_sr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_done <= byte_done_nxt;
            rw        <= rw_nxt;
            ptr       <= ptr_nxt;
            padoen    <= padoen_nxt;
            busy      <= busy_nxt;
            wr_stb    <= wr_stb_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)   rf      <= '0;
        else if (rf_we) rf[ptr] <= rx_byte;
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = padoen;
    assign busy_o       = busy;
    assign wr_stb_o     = wr_stb;
    assign wr_addr_o    = wr_addr;
    assign wr_data_o    = wr_data;
    assign loc_data_o   = rf[loc_addr_i];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bit-banged I2C master, register-file reference model and a scoreboard monitor
// that does every comparison.
module tb_i2c_slave_regfile;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int Q     = 8;   // quarter SCL period in wb clocks

    logic          clk;
    logic          rst;
    logic          scl_m, sda_m;
    logic          sda_pad_o, sda_padoen_o, busy, wr_stb;
    logic [AW-1:0] wr_addr, loc_addr;
    logic [7:0]    wr_data, loc_data;
    logic          sda_bus;

    assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

    i2c_slave_regfile #(.SLV_ADDR(7'h50), .DEPTH(DEPTH)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .scl_pad_i   (scl_m),
        .sda_pad_i   (sda_bus),
        .sda_pad_o   (sda_pad_o),
        .sda_padoen_o(sda_padoen_o),
        .busy_o      (busy),
        .wr_stb_o    (wr_stb),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .loc_addr_i  (loc_addr),
        .loc_data_o  (loc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { string name; int act; int exp; } chk_t;
    typedef struct { int a; int d; } wr_t;

    chk_t chk_q[$];
    wr_t  wr_q[$];
    chk_t mc;
    wr_t  mw;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   drive_cnt = 0;

    // reference model: byte array plus a persistent pointer
    logic [7:0]    mrf [DEPTH];
    logic [AW-1:0] mptr;
    logic [7:0]    none[$];

    always @(negedge clk) begin
        if (sda_padoen_o === 1'b0) drive_cnt++;
    end

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            total_cnt++;
            if (wr_q.size() == 0) begin
                $display("FAIL wr_stb: got addr=%0h data=%0h, expected no strobe", wr_addr, wr_data);
            end else begin
                mw = wr_q.pop_front();
                if (mw.a == int'(wr_addr) && mw.d == int'(wr_data)) pass_cnt++;
                else $display("FAIL wr_stb: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                              wr_addr, wr_data, mw.a, mw.d);
            end
        end
        while (chk_q.size() > 0) begin
            mc = chk_q.pop_front();
            total_cnt++;
            if (mc.act == mc.exp) pass_cnt++;
            else $display("FAIL %s: got %0h, expected %0h", mc.name, mc.act, mc.exp);
        end
    end

    task automatic push(input string name, input int act, input int exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop_c();
        wq(Q); sda_m = 1'b0;
        wq(Q); scl_m = 1'b1;
        wq(Q); sda_m = 1'b1;
        wq(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        wq(Q); sda_m = b;
        wq(Q); scl_m = 1'b1;
        wq(Q); s = sda_bus;
        wq(Q); scl_m = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b, output logic ack);
        logic [7:0] sh;
        logic       s;
        sh = b;
        for (int i = 0; i < 8; i++) begin
            clk_bit(sh[7], s);
            sh = {sh[6:0], 1'b0};
        end
        clk_bit(1'b1, ack);
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] b);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            b = {b[6:0], s};
        end
        clk_bit(nack, s);
    endtask

    task automatic wr_txn(input logic [7:0] p, input logic [7:0] data[$], input bit do_stop);
        logic ack;
        start_c();
        put_byte({7'h50, 1'b0}, ack);
        push("addr_w_ack", int'(ack), 0);
        push("busy_in_txn", int'(busy), 1);
        put_byte(p, ack);
        push("ptr_ack", int'(ack), 0);
        mptr = p[AW-1:0];
        foreach (data[i]) begin
            wr_q.push_back('{int'(mptr), int'(data[i])});
            mrf[mptr] = data[i];
            mptr = mptr + AW'(1);
            put_byte(data[i], ack);
            push("data_ack", int'(ack), 0);
        end
        if (do_stop) begin
            stop_c();
            push("busy_after_wr_stop", int'(busy), 0);
        end
    endtask

    task automatic rd_txn(input int n);
        logic       ack;
        logic [7:0] b;
        start_c();
        put_byte({7'h50, 1'b1}, ack);
        push("addr_r_ack", int'(ack), 0);
        for (int i = 0; i < n; i++) begin
            get_byte(i == n - 1, b);
            push("rd_data", int'(b), int'(mrf[mptr]));
            mptr = mptr + AW'(1);
        end
        push("busy_wait_stop", int'(busy), 1);
        stop_c();
        push("busy_after_rd_stop", int'(busy), 0);
    endtask

    task automatic loc_chk(input int a);
        logic [AW-1:0] la;
        la = a[AW-1:0];
        loc_addr = la;
        wq(1);
        push("loc_data", int'(loc_data), int'(mrf[la]));
    endtask

    task automatic chk_reset_outs();
        push("rst_padoen", int'(sda_padoen_o), 1);
        push("rst_busy", int'(busy), 0);
        push("rst_wr_stb", int'(wr_stb), 0);
        push("rst_wr_addr", int'(wr_addr), 0);
        push("rst_wr_data", int'(wr_data), 0);
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] q[$];
        int         dc, kind, n;
        logic [7:0] p;

        scl_m = 1'b1; sda_m = 1'b1; loc_addr = '0;
        for (int i = 0; i < DEPTH; i++) mrf[i] = '0;
        mptr = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        wq(3);
        chk_reset_outs();
        rst = 1'b0;
        wq(4);
        chk_reset_outs();
        for (int i = 0; i < DEPTH; i++) loc_chk(i);

        // write ptr 3, A5, 3C
        q = '{8'hA5, 8'h3C};
        wr_txn(8'h03, q, 1);
        loc_addr = 4'd3; wq(1); push("loc3_a5", int'(loc_data), 'hA5);
        loc_addr = 4'd4; wq(1); push("loc4_3c", int'(loc_data), 'h3C);

        // ptr 3 then repeated START and read two bytes
        wr_txn(8'h03, none, 0);
        rd_txn(2);

        // foreign address: no ACK, no drive, not busy
        dc = drive_cnt;
        start_c();
        put_byte({7'h51, 1'b0}, ack);
        push("nack_0x51", int'(ack), 1);
        push("busy_0x51", int'(busy), 0);
        stop_c();
        push("no_drive_0x51", drive_cnt - dc, 0);

        // pointer wrap at DEPTH
        q = '{8'h11, 8'h22};
        wr_txn(8'h0F, q, 1);
        loc_addr = 4'hF; wq(1); push("loc_f_11", int'(loc_data), 'h11);
        loc_addr = 4'h0; wq(1); push("loc_0_22", int'(loc_data), 'h22);

        // reset in the middle of a data byte
        wr_txn(8'h05, none, 0);
        for (int i = 0; i < 4; i++) clk_bit(i[0], s);
        wq(2);
        rst = 1'b1;
        #1;
        chk_reset_outs();
        for (int i = 0; i < DEPTH; i++) mrf[i] = '0;
        mptr = '0;
        wq(3);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) loc_chk(i);
        q = '{8'h5A, 8'hC3};
        wr_txn(8'h07, q, 1);
        wr_txn(8'h07, none, 0);
        rd_txn(2);

        // STOP in the middle of an address byte
        dc = drive_cnt;
        start_c();
        clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
        stop_c();
        push("no_drive_abort", drive_cnt - dc, 0);
        push("busy_abort", int'(busy), 0);
        q = '{8'h77};
        wr_txn(8'h02, q, 1);

        // randomized transactions against the model
        for (int t = 0; t < 18; t++) begin
            kind = int'($urandom_range(0, 3));
            n    = int'($urandom_range(1, 3));
            p    = 8'($urandom);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            case (kind)
                0: wr_txn(p, q, 1);
                1: rd_txn(n);
                2: begin wr_txn(p, none, 1); rd_txn(n); end
                default: begin wr_txn(p, none, 0); rd_txn(n); end
            endcase
            loc_chk(int'($urandom_range(0, DEPTH - 1)));
        end

        wq(10);
        push("wr_q_drained", wr_q.size(), 0);
        wq(3);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
